// File: rtl/cache_assoc_pkg.sv
// Shared widths, request/response/row types and byte-merge helpers for the
// set-associative cache model.
package cache_assoc_pkg;

  localparam int TAG_W    = 18;
  localparam int INDEX_W  = 12;
  localparam int NUM_SETS = 2 ** INDEX_W;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int BE_LSB   = $clog2(BE_W);
  localparam int MSI_W    = 2;
  localparam int WAYS     = 2;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [31:0] EXIT_ADDRESS0 = 32'h4000_1000;
  localparam logic [31:0] EXIT_ADDRESS1 = 32'h8000_1000;

  typedef struct packed {
    logic [BE_W-1:0]    byte_en;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [DATA_W-1:0]  data;
    logic               msi_valid;
    logic [MSI_W-1:0]   msi_data;
    logic               ignore_response;
  } cache_req_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [MSI_W-1:0]  msi;
  } cache_row_t;

  typedef struct packed {
    logic              hit;
    logic [WAY_W-1:0]  way;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [MSI_W-1:0]  msi;
  } cache_resp_t;

  function automatic logic [DATA_W-1:0] compute_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = be[i/8];
    end
    return mask;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_data,
                                                    input logic [DATA_W-1:0] new_data,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] mask;
    mask = compute_mask(be);
    return (old_data & ~mask) | (new_data & mask);
  endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// Put/get handshake bundle between a core memory stage (master) and the cache (slave).
interface cache_assoc_if;
  import cache_assoc_pkg::*;

  logic        put_valid;
  logic        put_ready;
  cache_req_t  put_request;
  logic        get_valid;
  logic        get_ready;
  cache_resp_t get_response;

  modport master (
    output put_valid, put_request, get_valid,
    input  put_ready, get_ready, get_response
  );

  modport slave (
    input  put_valid, put_request, get_valid,
    output put_ready, get_ready, get_response
  );

endinterface

// File: rtl/cache_resp_fifo.sv
// Response FIFO with a registered head word; a push and pop together are legal
// even when full, since the pop frees the slot being written.
module cache_resp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic [PTR_W-1:0] w_rd_next;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop     = i_pop && (r_count != '0);
  assign w_push    = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
  assign w_rd_next = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // the word being written becomes head when it lands on the next read slot
      r_head <= (w_push && (w_rd_next == r_wr_ptr)) ? i_data : r_mem[w_rd_next];
    end
  end

  assign o_data  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/cache_assoc.sv
// Set-associative cache model: registered lookup stage, tag match with per-set
// round-robin allocation, write-merge update and a decoupling response FIFO.
module cache_assoc
  import cache_assoc_pkg::*;
#(
  parameter int RESP_DEPTH = 2
) (
  input logic          CLK,
  input logic          RST_N,
  cache_assoc_if.slave io_bus
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  cache_req_t       r_stage;
  logic             r_stage_valid;
  cache_row_t       r_row [NUM_SETS][WAYS];
  logic [WAY_W-1:0] r_rr  [NUM_SETS];

  logic             w_put_wf;
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_sel;
  logic [WAY_W-1:0] w_rr_next;
  logic             w_has_be;
  cache_row_t       w_old_row;
  cache_row_t       w_new_row;
  cache_resp_t      w_resp;
  cache_resp_t      w_head;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;

  assign w_put_wf = io_bus.put_valid && io_bus.put_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stage_valid <= 1'b0;
      r_stage       <= '0;
    end else begin
      r_stage_valid <= w_put_wf;
      if (w_put_wf) begin
        r_stage <= io_bus.put_request;
      end
    end
  end

  // scan from the top way down so the lowest matching way wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_row[r_stage.index][w].tag == r_stage.tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_sel     = w_hit ? w_hit_way : r_rr[r_stage.index];
  assign w_old_row = r_row[r_stage.index][w_sel];
  assign w_has_be  = |r_stage.byte_en;
  assign w_rr_next = (r_rr[r_stage.index] == WAY_W'(WAYS - 1)) ? '0
                   : r_rr[r_stage.index] + 1'b1;

  always_comb begin
    w_new_row      = w_old_row;
    w_new_row.tag  = w_has_be ? r_stage.tag : w_old_row.tag;
    w_new_row.data = w_has_be ? merge_bytes(w_old_row.data, r_stage.data, r_stage.byte_en)
                              : w_old_row.data;
    w_new_row.msi  = r_stage.msi_valid ? r_stage.msi_data : w_old_row.msi;
  end

  always_comb begin
    w_resp      = '0;
    w_resp.hit  = w_hit;
    w_resp.way  = w_sel;
    w_resp.tag  = w_old_row.tag;
    w_resp.data = w_old_row.data;
    w_resp.msi  = w_old_row.msi;
  end

  // array is not reset; a write pending while reset is low is dropped
  always_ff @(posedge CLK) begin
    if (RST_N && r_stage_valid) begin
      r_row[r_stage.index][w_sel] <= w_new_row;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_rr[s] <= '0;
      end
    end else if (r_stage_valid && !w_hit && w_has_be) begin
      r_rr[r_stage.index] <= w_rr_next;
    end
  end

  assign w_push = r_stage_valid && !r_stage.ignore_response;
  assign w_pop  = io_bus.get_valid && io_bus.get_ready;

  cache_resp_fifo #(
    .WIDTH ($bits(cache_resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_push  (w_push),
    .i_data  (w_resp),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // the in-flight stage is reserved a slot even if it will not push
  assign w_occupancy         = {1'b0, w_count} + {{CNT_W{1'b0}}, r_stage_valid};
  assign io_bus.put_ready    = RST_N && (w_occupancy < (CNT_W + 1)'(RESP_DEPTH));
  assign io_bus.get_ready    = RST_N && (w_count != '0);
  assign io_bus.get_response = w_head;

`ifdef SIMULATION
  logic [31:0] w_put_addr;
  assign w_put_addr = 32'({io_bus.put_request.tag, io_bus.put_request.index, {BE_LSB{1'b0}}});

  always_ff @(posedge CLK) begin
    if (w_put_wf && ((w_put_addr == EXIT_ADDRESS0) || (w_put_addr == EXIT_ADDRESS1))) begin
      if (io_bus.put_request.data == '0) begin
        $display("PASS");
      end else begin
        $display("FAIL(%0d)", io_bus.put_request.data);
      end
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc: directed vector table, hand-written backpressure and
// mid-flight reset sequences, then random traffic against a per-line reference model.
module tb_cache_assoc;
  import cache_assoc_pkg::*;

  localparam int RESP_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_assoc_if bus ();

  cache_assoc #(.RESP_DEPTH(RESP_DEPTH)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference model: one record per (set, way), plus which fields are known
  logic [TAG_W-1:0]  m_tag  [NUM_SETS][WAYS];
  logic [DATA_W-1:0] m_data [NUM_SETS][WAYS];
  logic [MSI_W-1:0]  m_msi  [NUM_SETS][WAYS];
  bit                m_tk   [NUM_SETS][WAYS];
  bit                m_ak   [NUM_SETS][WAYS];
  int                m_rr   [NUM_SETS];

  typedef struct {
    cache_resp_t r;
    bit          tk;
    bit          ak;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model_access(input cache_req_t rq);
    exp_t e;
    int   s;
    int   sel;
    s   = int'(rq.index);
    sel = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (sel < 0 && m_tk[s][w] && m_tag[s][w] == rq.tag) sel = w;
    end
    e.r.hit = (sel >= 0);
    if (sel < 0) sel = m_rr[s];
    e.r.way  = WAY_W'(sel);
    e.r.tag  = m_tag[s][sel];
    e.r.data = m_data[s][sel];
    e.r.msi  = m_msi[s][sel];
    e.tk     = m_tk[s][sel];
    e.ak     = m_ak[s][sel];
    if (rq.byte_en != '0) begin
      m_tag[s][sel] = rq.tag;
      m_tk[s][sel]  = 1'b1;
      for (int b = 0; b < BE_W; b++) begin
        if (rq.byte_en[b]) m_data[s][sel][8*b +: 8] = rq.data[8*b +: 8];
      end
      if (!e.r.hit) m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    if (rq.msi_valid) m_msi[s][sel] = rq.msi_data;
    if (rq.byte_en == '1 && rq.msi_valid) m_ak[s][sel] = 1'b1;
    return e;
  endfunction

  task automatic compare_resp(input string name, input cache_resp_t act, input exp_t e);
    cache_resp_t a;
    cache_resp_t x;
    a = act;
    x = e.r;
    if (!e.tk) begin
      a.tag = '0;
      x.tag = '0;
    end
    if (!e.ak) begin
      a.data = '0; x.data = '0;
      a.msi  = '0; x.msi  = '0;
    end
    check(name, 64'(a), 64'(x));
  endtask

  function automatic cache_req_t mk(input logic [BE_W-1:0] be, input logic [TAG_W-1:0] tag,
                                    input logic [INDEX_W-1:0] idx, input logic [DATA_W-1:0] d,
                                    input logic mv, input logic [MSI_W-1:0] msi, input logic ign);
    cache_req_t r;
    r.byte_en         = be;
    r.tag             = tag;
    r.index           = idx;
    r.data            = d;
    r.msi_valid       = mv;
    r.msi_data        = msi;
    r.ignore_response = ign;
    return r;
  endfunction

  // all tasks start and end on a falling edge
  task automatic put(input cache_req_t rq);
    int n;
    n = 0;
    bus.put_request = rq;
    bus.put_valid   = 1'b1;
    while (!bus.put_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.put_ready) check("put_timeout", {63'b0, bus.put_ready}, 64'd1);
    @(negedge clk);
    bus.put_valid = 1'b0;
  endtask

  task automatic get(output cache_resp_t r);
    int n;
    n = 0;
    while (!bus.get_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.get_ready) check("get_timeout", {63'b0, bus.get_ready}, 64'd1);
    r = bus.get_response;
    bus.get_valid = 1'b1;
    @(negedge clk);
    bus.get_valid = 1'b0;
  endtask

  typedef struct {
    cache_req_t  req;
    cache_resp_t exp;
    bit          chk_row;
  } vec_t;

  function automatic vec_t mkv(input cache_req_t rq, input logic hit, input logic [WAY_W-1:0] way,
                               input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] d,
                               input logic [MSI_W-1:0] msi, input bit chk);
    vec_t v;
    v.req      = rq;
    v.exp.hit  = hit;
    v.exp.way  = way;
    v.exp.tag  = tag;
    v.exp.data = d;
    v.exp.msi  = msi;
    v.chk_row  = chk;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        vt[11];
    cache_resp_t resp;
    exp_t        e;
    exp_t        ev;
    cache_req_t  rq;
    int          pick;
    int          sets[4];

    sets[0] = 0; sets[1] = 1; sets[2] = 5; sets[3] = 7;
    for (int s = 0; s < NUM_SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_tk[s][w] = 1'b0;
        m_ak[s][w] = 1'b0;
      end
    end

    vt[0]  = mkv(mk(4'hF, 18'h1, 12'd5, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0), 1'b0, 1'b0, 18'h0, 32'h0, 2'd0, 1'b0);
    vt[1]  = mkv(mk(4'h0, 18'h1, 12'd5, 32'h0,        1'b0, 2'd0, 1'b0), 1'b1, 1'b0, 18'h1, 32'hDEADBEEF, 2'd2, 1'b1);
    vt[2]  = mkv(mk(4'h2, 18'h1, 12'd5, 32'h0000AA00, 1'b0, 2'd0, 1'b0), 1'b1, 1'b0, 18'h1, 32'hDEADBEEF, 2'd2, 1'b1);
    vt[3]  = mkv(mk(4'h0, 18'h1, 12'd5, 32'h0,        1'b0, 2'd0, 1'b0), 1'b1, 1'b0, 18'h1, 32'hDEADAAEF, 2'd2, 1'b1);
    vt[4]  = mkv(mk(4'hF, 18'hA, 12'd7, 32'h0000000A, 1'b1, 2'd1, 1'b0), 1'b0, 1'b0, 18'h0, 32'h0, 2'd0, 1'b0);
    vt[5]  = mkv(mk(4'hF, 18'hB, 12'd7, 32'h0000000B, 1'b1, 2'd1, 1'b0), 1'b0, 1'b1, 18'h0, 32'h0, 2'd0, 1'b0);
    vt[6]  = mkv(mk(4'hF, 18'hC, 12'd7, 32'h0000000C, 1'b1, 2'd3, 1'b0), 1'b0, 1'b0, 18'hA, 32'hA, 2'd1, 1'b1);
    vt[7]  = mkv(mk(4'h0, 18'hA, 12'd7, 32'h0,        1'b0, 2'd0, 1'b0), 1'b0, 1'b1, 18'hB, 32'hB, 2'd1, 1'b1);
    vt[8]  = mkv(mk(4'h0, 18'hC, 12'd7, 32'h0,        1'b0, 2'd0, 1'b0), 1'b1, 1'b0, 18'hC, 32'hC, 2'd3, 1'b1);
    vt[9]  = mkv(mk(4'h0, 18'hB, 12'd7, 32'h0,        1'b1, 2'd0, 1'b0), 1'b1, 1'b1, 18'hB, 32'hB, 2'd1, 1'b1);
    vt[10] = mkv(mk(4'h0, 18'hB, 12'd7, 32'h0,        1'b0, 2'd0, 1'b0), 1'b1, 1'b1, 18'hB, 32'hB, 2'd0, 1'b1);

    // reset with a request already presented
    bus.get_valid   = 1'b0;
    bus.put_valid   = 1'b1;
    bus.put_request = mk(4'hF, 18'h3, 12'd3, 32'h1, 1'b1, 2'd1, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_put_ready", {63'b0, bus.put_ready}, 64'd0);
    check("rst_get_ready", {63'b0, bus.get_ready}, 64'd0);
    check("rst_get_resp", 64'(bus.get_response), 64'd0);
    rst_n = 1'b1;
    bus.put_valid = 1'b0;
    @(negedge clk);
    check("rel_put_ready", {63'b0, bus.put_ready}, 64'd1);

    foreach (vt[i]) begin
      put(vt[i].req);
      ev = model_access(vt[i].req);
      get(resp);
      e.r  = vt[i].exp;
      e.tk = vt[i].chk_row;
      e.ak = vt[i].chk_row;
      compare_resp($sformatf("vec%0d", i), resp, e);
    end

    // backpressure: hold off the consumer and present three requests
    bus.put_request = mk(4'h0, 18'h1, 12'd5, 32'h0, 1'b0, 2'd0, 1'b0);
    bus.put_valid   = 1'b1;
    check("bp_ready0", {63'b0, bus.put_ready}, 64'd1);
    @(negedge clk);
    q.push_back(model_access(bus.put_request));
    check("bp_ready1", {63'b0, bus.put_ready}, 64'd1);
    bus.put_request = mk(4'h0, 18'hC, 12'd7, 32'h0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    q.push_back(model_access(bus.put_request));
    check("bp_ready2", {63'b0, bus.put_ready}, 64'd0);
    check("bp_get_ready", {63'b0, bus.get_ready}, 64'd1);
    bus.put_request = mk(4'h0, 18'hB, 12'd7, 32'h0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    check("bp_full", {63'b0, bus.put_ready}, 64'd0);
    compare_resp("bp_head", bus.get_response, q.pop_front());
    bus.get_valid = 1'b1;
    @(negedge clk);
    bus.get_valid = 1'b0;
    check("bp_after_pop", {63'b0, bus.put_ready}, 64'd1);
    ev = model_access(bus.put_request);
    @(negedge clk);
    bus.put_valid = 1'b0;
    get(resp);
    compare_resp("bp_second", resp, q.pop_front());
    check("ign_no_entry", {63'b0, bus.get_ready}, 64'd0);

    // reset between edges while a write sits in the lookup stage
    put(mk(4'h0, 18'h1, 12'd5, 32'h0, 1'b0, 2'd0, 1'b0));
    ev = model_access(mk(4'h0, 18'h1, 12'd5, 32'h0, 1'b0, 2'd0, 1'b0));
    put(mk(4'hF, 18'h55, 12'd9, 32'h12345678, 1'b1, 2'd1, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_get_ready", {63'b0, bus.get_ready}, 64'd0);
    check("mid_rst_put_ready", {63'b0, bus.put_ready}, 64'd0);
    check("mid_rst_resp", 64'(bus.get_response), 64'd0);
    q.delete();
    for (int s = 0; s < NUM_SETS; s++) m_rr[s] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_stale", {63'b0, bus.get_ready}, 64'd0);
    rq = mk(4'h0, 18'h55, 12'd9, 32'h0, 1'b0, 2'd0, 1'b0);
    put(rq);
    e = model_access(rq);
    get(resp);
    compare_resp("mid_rst_write_dropped", resp, e);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (q.size() >= 2 || (q.size() > 0 && $urandom_range(0, 2) == 0)) begin
        get(resp);
        compare_resp($sformatf("rand%0d", n), resp, q.pop_front());
      end else begin
        pick = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0:       rq.byte_en = 4'h0;
          3:       rq.byte_en = BE_W'($urandom);
          default: rq.byte_en = 4'hF;
        endcase
        rq.tag             = TAG_W'($urandom_range(1, 6));
        rq.index           = INDEX_W'(sets[pick]);
        rq.data            = $urandom;
        rq.msi_valid       = 1'($urandom);
        rq.msi_data        = MSI_W'($urandom);
        rq.ignore_response = ($urandom_range(0, 3) == 0);
        put(rq);
        e = model_access(rq);
        if (!rq.ignore_response) q.push_back(e);
      end
    end
    while (q.size() > 0) begin
      get(resp);
      compare_resp("drain", resp, q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
